fetch_axi_master: RTL and testbench

- Parametrised instruction-fetch AXI read master. Generates sequential fetch addresses and issues single-beat AXI AR requests of FETCH_WIDTH instructions each.
- Tracks up to MAX_OUTSTANDING in-flight requests and pairs each R response with its PC.
- On a jump redirect, discards the responses of all requests issued before the redirect.
- Sits between the PC/redirect logic and the instruction FIFO; its packed output feeds the FIFO directly.

---
 rtl/fetch_axi_master.sv | 230 +++++++++++++++++++++++
 tb/tb_fetch_axi_master.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_axi_master.sv
// Instruction-fetch AXI read master.
//
// Issues single-beat AXI read requests for sequential fetch blocks of
// FETCH_WIDTH instructions. Keeps a FIFO of the addresses in flight so that
// each R beat can be paired with its PC. Beats for requests issued before a
// jump are drained and discarded.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   jump, jump_addr   single-cycle redirect and its 4-byte aligned target
//   stop_fetch        downstream FIFO full: stall new requests and live delivery
//   ar*               AXI read-address channel (single beat, INCR)
//   r*                AXI read-data channel
//   fetch_valid       write strobe into the instruction FIFO
//   fetch_mask        per-slot valid (slots below the jump offset are masked)
//   fetch_err         delivered beat carried a non-OKAY response
//   fetch_instr_pc    slot i = {instr_i, pc_i} in bits [64i+63:64i]
module fetch_axi_master #(
    parameter int unsigned FETCH_WIDTH     = 2,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      jump,
    input  logic [31:0]               jump_addr,
    input  logic                      stop_fetch,
    input  logic                      arready,
    output logic                      arvalid,
    output logic [31:0]               araddr,
    output logic [7:0]                arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    input  logic                      rvalid,
    input  logic                      rlast,
    input  logic [1:0]                rresp,
    input  logic [32*FETCH_WIDTH-1:0] rdata,
    output logic                      rready,
    output logic                      fetch_valid,
    output logic [FETCH_WIDTH-1:0]    fetch_mask,
    output logic                      fetch_err,
    output logic [64*FETCH_WIDTH-1:0] fetch_instr_pc
);

    localparam int unsigned BYTE_SHIFT = $clog2(4 * FETCH_WIDTH);
    localparam logic [31:0] STEP       = 32'(4 * FETCH_WIDTH);
    localparam int unsigned OFF_W      = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam int unsigned PTR_W      = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W      = PTR_W + 1;

    // Every beat is single-transfer and full-width.
    assign arlen   = 8'd0;
    assign arsize  = 3'(BYTE_SHIFT);
    assign arburst = 2'b01;

    // rlast is always expected high since arlen is 0; nothing depends on it.
    logic unused_rlast;
    assign unused_rlast = rlast;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             arvalid_q, arvalid_d;
    logic [31:0]      araddr_q, araddr_d;
    logic [31:0]      next_pc_q, next_pc_d;
    logic [OFF_W-1:0] offset_q, offset_d;
    // Set when a jump lands while an AR is waiting for arready: that AR still
    // carries the old address and its beat must be dropped.
    logic             pend_stale_q, pend_stale_d;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0]                q_addr [MAX_OUTSTANDING];
    logic [OFF_W-1:0]           q_off  [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] q_stale_q;

    // ------------------------------------------------------------------
    // Handshakes and queue head
    // ------------------------------------------------------------------
    logic             q_empty;
    logic [31:0]      head_addr;
    logic [OFF_W-1:0] head_off;
    logic             head_stale;
    logic             ar_hs;
    logic             r_hs;
    logic             arm;
    logic [31:0]      jump_target;
    logic [OFF_W-1:0] jump_off;

    assign q_empty    = (count_q == '0);
    assign head_addr  = q_addr[rd_ptr_q];
    assign head_off   = q_off[rd_ptr_q];
    assign head_stale = !q_empty && q_stale_q[rd_ptr_q];

    // Stale beats are always accepted so a full FIFO cannot block the drain.
    assign rready = !stop_fetch || head_stale;
    assign ar_hs  = arvalid_q && arready;
    // A beat with nothing outstanding is a protocol error and is ignored.
    assign r_hs   = rvalid && rready && !q_empty;

    assign jump_target = jump_addr & ~(STEP - 32'd1);
    assign jump_off    = OFF_W'((jump_addr & (STEP - 32'd1)) >> 2);

    // The pending AR counts against the limit so it is never exceeded.
    assign arm = !stop_fetch && !jump &&
                 ((32'(count_q) + 32'(arvalid_q)) < MAX_OUTSTANDING);

    // ------------------------------------------------------------------
    // PC, offset and AR channel next state
    // ------------------------------------------------------------------
    always_comb begin
        next_pc_d    = next_pc_q;
        offset_d     = offset_q;
        pend_stale_d = pend_stale_q;
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;

        if (ar_hs) begin
            pend_stale_d = 1'b0;
            // A stale AR does not advance: next_pc already holds the jump target.
            if (!pend_stale_q) begin
                next_pc_d = next_pc_q + STEP;
                offset_d  = '0;
            end
        end else if (jump && arvalid_q) begin
            pend_stale_d = 1'b1;
        end

        if (jump) begin
            next_pc_d = jump_target;
            offset_d  = jump_off;
        end

        // An asserted AR is never retracted; re-arm only once it is accepted.
        if (!arvalid_q || arready) begin
            arvalid_d = arm;
            if (arm) begin
                araddr_d = next_pc_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Queue pointers and occupancy
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (ar_hs) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (r_hs) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({ar_hs, r_hs})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            arvalid_q    <= 1'b0;
            araddr_q     <= RESET_PC;
            next_pc_q    <= RESET_PC;
            offset_q     <= '0;
            pend_stale_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            next_pc_q    <= next_pc_d;
            offset_q     <= offset_d;
            pend_stale_q <= pend_stale_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Address/offset storage needs no reset: occupancy guards every read.
    always_ff @(posedge clk) begin
        if (ar_hs) begin
            q_addr[wr_ptr_q] <= araddr_q;
            q_off[wr_ptr_q]  <= offset_q;
        end
    end

    // A jump marks everything present at the end of its cycle, including an
    // entry pushed in that same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_stale_q <= '0;
        end else begin
            if (ar_hs) begin
                q_stale_q[wr_ptr_q] <= pend_stale_q;
            end
            if (jump) begin
                q_stale_q <= '1;
            end
        end
    end

    assign arvalid = arvalid_q;
    assign araddr  = araddr_q;

    // ------------------------------------------------------------------
    // Delivery to the instruction FIFO
    // ------------------------------------------------------------------
    always_comb begin
        fetch_valid    = r_hs && !head_stale && !jump;
        fetch_mask     = '0;
        fetch_err      = 1'b0;
        fetch_instr_pc = '0;
        if (fetch_valid) begin
            fetch_err = (rresp != 2'b00);
            for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
                fetch_mask[i]              = (i >= 32'(head_off));
                fetch_instr_pc[64*i +: 64] = {rdata[32*i +: 32], head_addr + 32'(4 * i)};
            end
        end
    end

endmodule

// File: tb/tb_fetch_axi_master.sv
module tb_fetch_axi_master;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         jump;
    logic [31:0]  jump_addr;
    logic         stop_fetch;
    logic         arready;
    logic         arvalid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         rvalid;
    logic         rlast;
    logic [1:0]   rresp;
    logic [63:0]  rdata;
    logic         rready;
    logic         fetch_valid;
    logic [1:0]   fetch_mask;
    logic         fetch_err;
    logic [127:0] fetch_instr_pc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_axi_master #(
        .FETCH_WIDTH     (2),
        .MAX_OUTSTANDING (4),
        .RESET_PC        (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .jump           (jump),
        .jump_addr      (jump_addr),
        .stop_fetch     (stop_fetch),
        .arready        (arready),
        .arvalid        (arvalid),
        .araddr         (araddr),
        .arlen          (arlen),
        .arsize         (arsize),
        .arburst        (arburst),
        .rvalid         (rvalid),
        .rlast          (rlast),
        .rresp          (rresp),
        .rdata          (rdata),
        .rready         (rready),
        .fetch_valid    (fetch_valid),
        .fetch_mask     (fetch_mask),
        .fetch_err      (fetch_err),
        .fetch_instr_pc (fetch_instr_pc)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        jump       = 1'b0;
        jump_addr  = '0;
        stop_fetch = 1'b0;
        arready    = 1'b0;
        rvalid     = 1'b0;
        rlast      = 1'b1;
        rresp      = 2'b00;
        rdata      = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [31:0] hs_addr [8];
    int          hs_cnt;

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        settle();
        check_eq("rst_arvalid", arvalid, 1'b0);
        check_eq("rst_araddr", araddr, 32'h0);
        check_eq("rst_fetch_valid", fetch_valid, 1'b0);
        check_eq("rst_fetch_mask", fetch_mask, 2'b00);
        check_eq("rst_fetch_err", fetch_err, 1'b0);
        check_eq("arlen", arlen, 8'd0);
        check_eq("arsize", arsize, 3'd3);
        check_eq("arburst", arburst, 2'b01);
        // Beat with nothing outstanding is ignored
        rvalid = 1'b1;
        settle();
        check_eq("empty_rvalid_ignored", fetch_valid, 1'b0);
        rvalid = 1'b0;

        // ---------------- basic sequential fetch ----------------
        arready = 1'b1;
        tick();
        settle();
        check_eq("t1_first_arvalid", arvalid, 1'b1);
        check_eq("t1_araddr0", araddr, 32'h0);
        tick();
        settle();
        check_eq("t1_araddr8", araddr, 32'h8);
        rvalid = 1'b1;
        rdata  = 64'h0000000B_0000000A;
        settle();
        check_eq("t1_fetch_valid", fetch_valid, 1'b1);
        check_eq("t1_instr_pc", fetch_instr_pc, 128'h0000000B_00000004_0000000A_00000000);
        check_eq("t1_mask", fetch_mask, 2'b11);
        tick();
        settle();
        check_eq("t1_araddr10", araddr, 32'h10);
        rvalid  = 1'b0;
        arready = 1'b0;
        settle();
        check_eq("t1_idle_valid", fetch_valid, 1'b0);
        check_eq("t1_idle_instr_pc", fetch_instr_pc, 128'h0);

        // ---------------- outstanding limit ----------------
        do_reset();
        arready = 1'b1;
        hs_cnt  = 0;
        for (int i = 0; i < 10; i++) begin
            settle();
            if (arvalid && arready) begin
                if (hs_cnt < 8) hs_addr[hs_cnt] = araddr;
                hs_cnt++;
            end
            tick();
        end
        check_eq("t2_hs_count", 128'(hs_cnt), 128'd4);
        check_eq("t2_hs0", hs_addr[0], 32'h00);
        check_eq("t2_hs1", hs_addr[1], 32'h08);
        check_eq("t2_hs2", hs_addr[2], 32'h10);
        check_eq("t2_hs3", hs_addr[3], 32'h18);
        settle();
        check_eq("t2_full_arvalid", arvalid, 1'b0);
        rvalid = 1'b1;
        rdata  = 64'h0000000D_0000000C;
        settle();
        check_eq("t2_resp_pc", fetch_instr_pc, 128'h0000000D_00000004_0000000C_00000000);
        tick();
        rvalid = 1'b0;
        settle();
        check_eq("t2_pop_cycle_arvalid", arvalid, 1'b0);
        tick();
        settle();
        check_eq("t2_rearm_arvalid", arvalid, 1'b1);
        check_eq("t2_rearm_araddr", araddr, 32'h20);

        // ---------------- jump with three outstanding ----------------
        do_reset();
        arready = 1'b1;
        tick();
        tick();
        tick();
        stop_fetch = 1'b1;
        tick();
        stop_fetch = 1'b0;
        arready    = 1'b0;
        jump       = 1'b1;
        jump_addr  = 32'h104;
        settle();
        check_eq("t3_jump_arvalid", arvalid, 1'b0);
        tick();
        jump       = 1'b0;
        stop_fetch = 1'b1;
        rvalid     = 1'b1;
        rdata      = 64'hDEADDEAD_BEEFBEEF;
        for (int i = 0; i < 3; i++) begin
            settle();
            check_eq("t3_stale_rready", rready, 1'b1);
            check_eq("t3_stale_dropped", fetch_valid, 1'b0);
            tick();
        end
        rvalid = 1'b0;
        settle();
        check_eq("t3_drained_rready", rready, 1'b0);
        check_eq("t3_stalled_arvalid", arvalid, 1'b0);
        stop_fetch = 1'b0;
        tick();
        settle();
        check_eq("t3_target_arvalid", arvalid, 1'b1);
        check_eq("t3_target_araddr", araddr, 32'h100);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 64'h22222222_11111111;
        settle();
        check_eq("t3_next_araddr", araddr, 32'h108);
        check_eq("t3_fetch_valid", fetch_valid, 1'b1);
        check_eq("t3_mask", fetch_mask, 2'b10);
        check_eq("t3_instr_pc", fetch_instr_pc, 128'h22222222_00000104_11111111_00000100);
        tick();
        rvalid = 1'b0;

        // ---------------- stop_fetch with a live head ----------------
        do_reset();
        arready = 1'b1;
        tick();
        stop_fetch = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 64'h44444444_33333333;
        settle();
        check_eq("t4_stop_rready", rready, 1'b0);
        check_eq("t4_stop_valid", fetch_valid, 1'b0);
        check_eq("t4_stop_arvalid", arvalid, 1'b0);
        tick();
        settle();
        check_eq("t4_still_arvalid", arvalid, 1'b0);
        check_eq("t4_still_valid", fetch_valid, 1'b0);
        stop_fetch = 1'b0;
        settle();
        check_eq("t4_release_valid", fetch_valid, 1'b1);
        check_eq("t4_release_pc", fetch_instr_pc, 128'h44444444_00000004_33333333_00000000);
        tick();
        rvalid = 1'b0;
        settle();
        check_eq("t4_rearm_arvalid", arvalid, 1'b1);
        check_eq("t4_rearm_araddr", araddr, 32'h8);

        // ---------------- jump while AR pending ----------------
        do_reset();
        tick();
        jump      = 1'b1;
        jump_addr = 32'h40;
        tick();
        jump = 1'b0;
        settle();
        check_eq("t5_held_arvalid", arvalid, 1'b1);
        check_eq("t5_held_araddr", araddr, 32'h0);
        arready = 1'b1;
        tick();
        settle();
        check_eq("t5_target_araddr", araddr, 32'h40);
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 64'hAAAAAAAA_BBBBBBBB;
        settle();
        check_eq("t5_stale_rready", rready, 1'b1);
        check_eq("t5_stale_dropped", fetch_valid, 1'b0);
        tick();
        rvalid  = 1'b0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 64'h66666666_55555555;
        settle();
        check_eq("t5_live_valid", fetch_valid, 1'b1);
        check_eq("t5_live_pc", fetch_instr_pc, 128'h66666666_00000044_55555555_00000040);
        tick();
        rvalid = 1'b0;

        // ---------------- address wrap and error response ----------------
        do_reset();
        jump      = 1'b1;
        jump_addr = 32'hFFFF_FFF8;
        tick();
        jump = 1'b0;
        tick();
        settle();
        check_eq("t6_high_araddr", araddr, 32'hFFFF_FFF8);
        arready = 1'b1;
        tick();
        settle();
        check_eq("t6_wrap_araddr", araddr, 32'h0);
        arready = 1'b0;
        rvalid  = 1'b1;
        rresp   = 2'b10;
        rdata   = 64'h88888888_77777777;
        settle();
        check_eq("t6_err_valid", fetch_valid, 1'b1);
        check_eq("t6_err", fetch_err, 1'b1);
        check_eq("t6_err_pc", fetch_instr_pc, 128'h88888888_FFFFFFFC_77777777_FFFFFFF8);
        tick();
        rvalid = 1'b0;
        rresp  = 2'b00;
        // Live beat arriving in a jump cycle is popped but not delivered
        arready = 1'b1;
        tick();
        arready   = 1'b0;
        rvalid    = 1'b1;
        jump      = 1'b1;
        jump_addr = 32'h200;
        settle();
        check_eq("t6_jump_cycle_rready", rready, 1'b1);
        check_eq("t6_jump_cycle_dropped", fetch_valid, 1'b0);
        tick();
        jump   = 1'b0;
        rvalid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
